// File: rtl/ma_splitter.sv
// Source end of the ma lane interface: streams a loaded WIDTH-bit count as up to four lane pulses per cycle.
// Optional MA_SPLITTER_ABORT_EN adds an abort input that cancels a burst in progress without a done pulse.
module ma_splitter #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst,
`ifdef MA_SPLITTER_ABORT_EN
    input  logic             abort,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    output logic             ready,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             valid,
    output logic             done,
    output logic [WIDTH-1:0] remaining
);

    typedef enum logic [1:0] {IDLE, EMIT, DONE} state_e;

    state_e           state_q, state_d;
    logic [3:0]       lanes_q, lanes_d;   // bit 0 drives a, bit 3 drives d
    logic             valid_q, valid_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] remaining_q, remaining_d;
    logic             abort_w;

`ifdef MA_SPLITTER_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    function automatic logic [3:0] chunk(input logic [WIDTH-1:0] r);
        if (r >= WIDTH'(4)) return 4'b1111;
        case (r[1:0])
            2'd3:    return 4'b0111;
            2'd2:    return 4'b0011;
            2'd1:    return 4'b0001;
            default: return 4'b0000;
        endcase
    endfunction

    // Never exceeds r, so remaining cannot underflow.
    function automatic logic [WIDTH-1:0] take(input logic [WIDTH-1:0] r);
        return (r >= WIDTH'(4)) ? WIDTH'(4) : r;
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        state_d     = state_q;
        lanes_d     = lanes_q;
        valid_d     = valid_q;
        done_d      = 1'b0;
        remaining_d = remaining_q;

        case (state_q)
            IDLE: begin
                lanes_d     = 4'b0000;
                valid_d     = 1'b0;
                remaining_d = '0;
                if (load) begin
                    if (value != '0) begin
                        lanes_d     = chunk(value);
                        valid_d     = 1'b1;
                        remaining_d = value - take(value);
                        state_d     = EMIT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            EMIT: begin
                if (abort_w) begin
                    lanes_d     = 4'b0000;
                    valid_d     = 1'b0;
                    remaining_d = '0;
                    state_d     = IDLE;
                end else if (remaining_q != '0) begin
                    lanes_d     = chunk(remaining_q);
                    remaining_d = remaining_q - take(remaining_q);
                end else begin
                    lanes_d = 4'b0000;
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                lanes_d     = 4'b0000;
                valid_d     = 1'b0;
                remaining_d = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            lanes_q     <= 4'b0000;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            remaining_q <= '0;
        end else begin
            state_q     <= state_d;
            lanes_q     <= lanes_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            remaining_q <= remaining_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign a         = lanes_q[0];
    assign b         = lanes_q[1];
    assign c         = lanes_q[2];
    assign d         = lanes_q[3];
    assign valid     = valid_q;
    assign done      = done_q;
    assign remaining = remaining_q;

endmodule

// File: tb/tb_ma_splitter.sv
// Directed bench for ma_splitter: a scoreboard queue holds the expected lane pattern and
// remaining count for every valid cycle of a burst; define MA_SPLITTER_ABORT_EN to exercise abort.
module tb_ma_splitter;

    localparam int WIDTH = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic [WIDTH-1:0] value = '0;
`ifdef MA_SPLITTER_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             ready, a, b, c, d, valid, done;
    logic [WIDTH-1:0] remaining;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [3:0]       lanes;
        logic [WIDTH-1:0] rem;
    } exp_t;

    exp_t sb[$];

    ma_splitter #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef MA_SPLITTER_ABORT_EN
        .abort     (abort),
`endif
        .load      (load),
        .value     (value),
        .ready     (ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .valid     (valid),
        .done      (done),
        .remaining (remaining)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected stream: each cycle carries min(r,4) lanes packed from lane a upward.
    task automatic push_expected(input int v);
        int r = v;
        int n;
        exp_t e;
        while (r > 0) begin
            n = (r > 4) ? 4 : r;
            r = r - n;
            e.lanes = 4'((1 << n) - 1);
            e.rem   = WIDTH'(r);
            sb.push_back(e);
        end
    endtask

    function automatic logic [3:0] lanes_now();
        return {d, c, b, a};
    endfunction

    task automatic check_idle(input string tag);
        check({tag, "_valid"}, 32'(valid), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_ready"}, 32'(ready), 32'd1);
        check({tag, "_lanes"}, 32'(lanes_now()), 32'd0);
        check({tag, "_rem"}, 32'(remaining), 32'd0);
    endtask

    // Loads v, checks every valid cycle against the scoreboard, then the done pulse and the return
    // to ready. A load with value 3 is driven during valid cycle mid_load_at (negative: never).
    task automatic run_burst(input string tag, input int v, input int mid_load_at);
        int   acc = 0;
        int   idx = 0;
        exp_t e;
        push_expected(v);
        load  = 1'b1;
        value = WIDTH'(v);
        step();
        load = 1'b0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_valid"}, 32'(valid), 32'd1);
            check({tag, "_lanes"}, 32'(lanes_now()), 32'(e.lanes));
            check({tag, "_rem"}, 32'(remaining), 32'(e.rem));
            check({tag, "_busy"}, 32'(ready), 32'd0);
            check({tag, "_nodone"}, 32'(done), 32'd0);
            acc = acc + int'(a) + int'(b) + int'(c) + int'(d);
            if (idx == mid_load_at) begin
                load  = 1'b1;
                value = WIDTH'(3);
            end else begin
                load = 1'b0;
            end
            idx++;
            step();
        end
        load = 1'b0;
        check({tag, "_end_valid"}, 32'(valid), 32'd0);
        check({tag, "_end_done"}, 32'(done), 32'd1);
        check({tag, "_end_lanes"}, 32'(lanes_now()), 32'd0);
        check({tag, "_end_busy"}, 32'(ready), 32'd0);
        check({tag, "_sum"}, 32'(acc), 32'(v));
        step();
        check({tag, "_post_done"}, 32'(done), 32'd0);
        check({tag, "_post_ready"}, 32'(ready), 32'd1);
    endtask

    initial begin
        exp_t e;

        // Reset asserted from time zero: outputs cleared before any clock edge.
        #3;
        check_idle("reset_init");
        rst = 1'b0;
        step();
        check_idle("idle_after_reset");

        // Asynchronous reset pulse in mid-cycle while idle.
        #2 rst = 1'b1;
        #1 check_idle("reset_pulse");
        rst = 1'b0;
        step();

        run_burst("v9", 9, -1);
        run_burst("v0", 0, -1);
        run_burst("v31", 31, 3);
        run_burst("v1", 1, -1);
        run_burst("v4", 4, -1);

        // Reset during the second valid cycle of a value-6 burst.
        push_expected(6);
        load  = 1'b1;
        value = WIDTH'(6);
        step();
        load = 1'b0;
        e = sb.pop_front();
        check("v6_c0_lanes", 32'(lanes_now()), 32'(e.lanes));
        check("v6_c0_rem", 32'(remaining), 32'(e.rem));
        step();
        e = sb.pop_front();
        check("v6_c1_lanes", 32'(lanes_now()), 32'(e.lanes));
        check("v6_c1_rem", 32'(remaining), 32'(e.rem));
        #2 rst = 1'b1;
        #1 check_idle("v6_reset");
        sb.delete();
        rst = 1'b0;
        step();
        check_idle("v6_after_reset");
        run_burst("v2", 2, -1);

`ifdef MA_SPLITTER_ABORT_EN
        // Abort on the second EMIT edge of a value-20 burst.
        load  = 1'b1;
        value = WIDTH'(20);
        step();
        load = 1'b0;
        check("ab_c0_valid", 32'(valid), 32'd1);
        check("ab_c0_rem", 32'(remaining), 32'd16);
        step();
        check("ab_c1_valid", 32'(valid), 32'd1);
        check("ab_c1_rem", 32'(remaining), 32'd12);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_idle("ab_cut");
        step();
        check_idle("ab_after");
        run_burst("ab_v5", 5, -1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
